// File: rtl/sink_config_pkg.sv
// Shared sink-path configuration: sink word width, serializer byte geometry,
// and the serializer FSM state encoding.
package sink_config;

    localparam int SNK_WIDTH     = 16;
    localparam int SER_BYTE_W    = 8;
    localparam int SER_NUM_BYTES = (SNK_WIDTH + SER_BYTE_W - 1) / SER_BYTE_W;

    // HDR is only reachable when SINK_SERIALIZER_HEADER_EN is defined.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2
    } ser_state_t;

endpackage : sink_config

// File: rtl/sink_serializer.sv
// Splits each sink word into an MSB-first byte stream, zero-padding the last byte.
// Optional SINK_SERIALIZER_HEADER_EN prefixes every word with {1'b1, seq[6:0]}.
module sink_serializer
    import sink_config::*;
#(
    parameter  int WIDTH     = SNK_WIDTH,
    localparam int NUM_BYTES = (WIDTH + SER_BYTE_W - 1) / SER_BYTE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    input  logic [WIDTH-1:0]      snk,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic [SER_BYTE_W-1:0] byte_data
);

    localparam int SR_W  = NUM_BYTES * SER_BYTE_W;
    localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

`ifdef SINK_SERIALIZER_HEADER_EN
    localparam ser_state_t FIRST_ST = HDR;
`else
    localparam ser_state_t FIRST_ST = SEND;
`endif

    ser_state_t       state_q, state_d;
    logic [SR_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [SR_W-1:0]  load_word;
`ifdef SINK_SERIALIZER_HEADER_EN
    logic [6:0]       seq_q,   seq_d;
`endif

    // Word left-justified in the shift register; unused low bits stay zero.
    always_comb begin
        load_word                    = '0;
        load_word[SR_W-1 -: WIDTH]   = snk;
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
`ifdef SINK_SERIALIZER_HEADER_EN
        seq_d      = seq_q;
`endif
        snk_ready  = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;

        unique case (state_q)
            IDLE: begin
                snk_ready = 1'b1;
                if (snk_valid) begin
                    shift_d = load_word;
                    cnt_d   = LAST_CNT;
                    state_d = FIRST_ST;
                end
            end

            HDR: begin
`ifdef SINK_SERIALIZER_HEADER_EN
                byte_valid = 1'b1;
                byte_data  = {1'b1, seq_q};
                if (byte_ready) begin
                    seq_d   = seq_q + 7'd1;
                    state_d = SEND;
                end
`else
                state_d = IDLE;
`endif
            end

            SEND: begin
                byte_valid = 1'b1;
                byte_data  = shift_q[SR_W-1 -: SER_BYTE_W];
                if (byte_ready) begin
                    if (cnt_q != '0) begin
                        shift_d = shift_q << SER_BYTE_W;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else begin
                        // Last byte leaves: a waiting word reloads with no bubble.
                        snk_ready = 1'b1;
                        if (snk_valid) begin
                            shift_d = load_word;
                            cnt_d   = LAST_CNT;
                            state_d = FIRST_ST;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the shift register
    // is reset too so byte_data is deterministic from the first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef SINK_SERIALIZER_HEADER_EN
            seq_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef SINK_SERIALIZER_HEADER_EN
            seq_q   <= seq_d;
`endif
        end
    end

endmodule : sink_serializer

// File: tb/tb_sink_serializer.sv
// Directed bench for sink_serializer at WIDTH = 10, 16, 3 and 8; header mode
// is exercised when SINK_SERIALIZER_HEADER_EN is defined for the build.
module tb_sink_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        sv_10, sr_10, bv_10, br_10;
    logic [9:0]  s_10;
    logic [7:0]  bd_10;
    logic        sv_16, sr_16, bv_16, br_16;
    logic [15:0] s_16;
    logic [7:0]  bd_16;
    logic        sv_3, sr_3, bv_3, br_3;
    logic [2:0]  s_3;
    logic [7:0]  bd_3;
    logic        sv_8, sr_8, bv_8, br_8;
    logic [7:0]  s_8;
    logic [7:0]  bd_8;

    sink_serializer #(.WIDTH(10)) u_w10 (
        .clk(clk), .rst(rst), .snk_valid(sv_10), .snk_ready(sr_10), .snk(s_10),
        .byte_valid(bv_10), .byte_ready(br_10), .byte_data(bd_10));
    sink_serializer #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .snk_valid(sv_16), .snk_ready(sr_16), .snk(s_16),
        .byte_valid(bv_16), .byte_ready(br_16), .byte_data(bd_16));
    sink_serializer #(.WIDTH(3)) u_w3 (
        .clk(clk), .rst(rst), .snk_valid(sv_3), .snk_ready(sr_3), .snk(s_3),
        .byte_valid(bv_3), .byte_ready(br_3), .byte_data(bd_3));
    sink_serializer #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .snk_valid(sv_8), .snk_ready(sr_8), .snk(s_8),
        .byte_valid(bv_8), .byte_ready(br_8), .byte_data(bd_8));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge; inputs are changed and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sv_10 = 1'b0; br_10 = 1'b1; s_10 = '0;
        sv_16 = 1'b0; br_16 = 1'b1; s_16 = '0;
        sv_3  = 1'b0; br_3  = 1'b1; s_3  = '0;
        sv_8  = 1'b0; br_8  = 1'b1; s_8  = '0;

        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_bv16", 32'(bv_16), 32'h0);
        check("rst_bd16", 32'(bd_16), 32'h00);
        check("rst_sr16", 32'(sr_16), 32'h1);
        check("rst_bv10", 32'(bv_10), 32'h0);

`ifdef SINK_SERIALIZER_HEADER_EN
        // 130 words: headers 0x80..0xFF, then wrap to 0x80, 0x81.
        for (int i = 0; i < 130; i++) begin
            sv_8 = 1'b1;
            s_8  = 8'(i * 3 + 1);
            #1;
            check("hdr_sr_idle", 32'(sr_8), 32'h1);
            tick();
            sv_8 = 1'b0;
            #1;
            check("hdr_bv", 32'(bv_8), 32'h1);
            check("hdr_byte", 32'(bd_8), 32'(8'h80 | 8'(i % 128)));
            tick();
            check("hdr_data", 32'(bd_8), 32'(8'(i * 3 + 1)));
            tick();
            check("hdr_idle", 32'(bv_8), 32'h0);
        end
`else
        // WIDTH=10: 10'h2A5 -> 0xA9, 0x40, then idle.
        sv_10 = 1'b1;
        s_10  = 10'h2A5;
        #1;
        check("w10_sr_idle", 32'(sr_10), 32'h1);
        tick();
        sv_10 = 1'b0;
        #1;
        check("w10_bv0", 32'(bv_10), 32'h1);
        check("w10_b0", 32'(bd_10), 32'hA9);
        check("w10_sr_b0", 32'(sr_10), 32'h0);
        tick();
        check("w10_bv1", 32'(bv_10), 32'h1);
        check("w10_b1", 32'(bd_10), 32'h40);
        check("w10_sr_b1", 32'(sr_10), 32'h1);
        tick();
        check("w10_idle", 32'(bv_10), 32'h0);

        // WIDTH=16: three back-to-back words with no gap cycles.
        sv_16 = 1'b1;
        s_16  = 16'h1234;
        #1;
        check("b2b_sr_first", 32'(sr_16), 32'h1);
        tick();
        s_16 = 16'hABCD;
        #1;
        check("b2b_12", 32'(bd_16), 32'h12);
        check("b2b_sr_12", 32'(sr_16), 32'h0);
        tick();
        check("b2b_34", 32'(bd_16), 32'h34);
        check("b2b_sr_34", 32'(sr_16), 32'h1);
        tick();
        s_16 = 16'h00FF;
        #1;
        check("b2b_AB", 32'(bd_16), 32'hAB);
        check("b2b_bv_AB", 32'(bv_16), 32'h1);
        check("b2b_sr_AB", 32'(sr_16), 32'h0);
        tick();
        check("b2b_CD", 32'(bd_16), 32'hCD);
        check("b2b_sr_CD", 32'(sr_16), 32'h1);
        tick();
        sv_16 = 1'b0;
        #1;
        check("b2b_00", 32'(bd_16), 32'h00);
        check("b2b_bv_00", 32'(bv_16), 32'h1);
        check("b2b_sr_00", 32'(sr_16), 32'h0);
        tick();
        check("b2b_FF", 32'(bd_16), 32'hFF);
        check("b2b_sr_FF", 32'(sr_16), 32'h1);
        tick();
        check("b2b_idle", 32'(bv_16), 32'h0);

        // WIDTH=16 stall: byte_ready 1,0,0,1 holds 0x34 on the output.
        sv_16 = 1'b1;
        s_16  = 16'h1234;
        tick();
        sv_16 = 1'b0;
        #1;
        check("stl_12", 32'(bd_16), 32'h12);
        tick();
        br_16 = 1'b0;
        #1;
        check("stl_34_a", 32'(bd_16), 32'h34);
        check("stl_sr_a", 32'(sr_16), 32'h0);
        tick();
        check("stl_34_b", 32'(bd_16), 32'h34);
        check("stl_bv_b", 32'(bv_16), 32'h1);
        check("stl_sr_b", 32'(sr_16), 32'h0);
        br_16 = 1'b1;
        #1;
        check("stl_34_c", 32'(bd_16), 32'h34);
        check("stl_sr_c", 32'(sr_16), 32'h1);
        tick();
        check("stl_idle", 32'(bv_16), 32'h0);

        // WIDTH=3: 3'b101 -> single byte 0xA0.
        sv_3 = 1'b1;
        s_3  = 3'b101;
        tick();
        sv_3 = 1'b0;
        #1;
        check("w3_bv", 32'(bv_3), 32'h1);
        check("w3_b0", 32'(bd_3), 32'hA0);
        check("w3_sr", 32'(sr_3), 32'h1);
        tick();
        check("w3_idle", 32'(bv_3), 32'h0);

        // Reset after the first byte of 0x1234 drops the remaining 0x34.
        sv_16 = 1'b1;
        s_16  = 16'h1234;
        tick();
        sv_16 = 1'b0;
        #1;
        check("rmw_12", 32'(bd_16), 32'h12);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rmw_bv", 32'(bv_16), 32'h0);
        check("rmw_sr", 32'(sr_16), 32'h1);
        check("rmw_bd", 32'(bd_16), 32'h00);
        tick();
        check("rmw_bv2", 32'(bv_16), 32'h0);
        sv_16 = 1'b1;
        s_16  = 16'hABCD;
        tick();
        sv_16 = 1'b0;
        #1;
        check("rmw_AB", 32'(bd_16), 32'hAB);
        tick();
        check("rmw_CD", 32'(bd_16), 32'hCD);
        tick();
        check("rmw_idle", 32'(bv_16), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sink_serializer
